// File: rtl/fire7_pkg.sv
// fire7_pkg: shared state encoding and layer geometry for the fire7 writers
package fire7_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  localparam int FIRE7_NPIX = 256;
  localparam int FIRE7_CH_TOTAL = 384;
  localparam int FIRE7_EX1_OFFSET = 0;
  localparam int FIRE7_EX3_OFFSET = 192;
endpackage

// File: rtl/fire7_ex_1_ofm_writer.sv
// fire7_ex_1_ofm_writer: serializes expand-1x1 pixel vectors into lane-wide writes to the concat buffer
module fire7_ex_1_ofm_writer
  import fire7_pkg::*;
#(
  parameter int DSP_NO = 192,
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int NPIX = FIRE7_NPIX,
  parameter int CH_TOTAL = FIRE7_CH_TOTAL,
  parameter int CH_OFFSET = FIRE7_EX1_OFFSET,
  parameter int BEATS = DSP_NO / LANES,
  parameter int ADDR_W = $clog2(NPIX * CH_TOTAL / LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      vec_valid,
  input  logic [WIDTH-1:0]          vec_in [DSP_NO],
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LANES*WIDTH-1:0]    wr_data,
  output logic                      busy,
  output logic                      overflow,
  output logic                      done
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW = NPIX > 1 ? $clog2(NPIX) : 1;
  if (DSP_NO % LANES != 0 || CH_TOTAL % LANES != 0 || CH_OFFSET % LANES != 0) begin : g_bad_align
    $error("DSP_NO, CH_TOTAL and CH_OFFSET must be multiples of LANES");
  end
  if (CH_OFFSET + DSP_NO > CH_TOTAL) begin : g_bad_range
    $error("CH_OFFSET + DSP_NO exceeds CH_TOTAL");
  end
  state_t state;
  logic [PW-1:0] pixel;
  logic [BW-1:0] beat;
  logic [DSP_NO*WIDTH-1:0] flat_in, shadow;
  logic fire, last_beat, last_pix, capture;
  for (genvar i = 0; i < DSP_NO; i++) begin : g_flat
    assign flat_in[i*WIDTH +: WIDTH] = vec_in[i];
  end
  assign fire = state == DRAIN && wr_ready;
  assign last_beat = beat == BW'(BEATS - 1);
  assign last_pix = pixel == PW'(NPIX - 1);
  // a vector arriving on the completing final beat chains straight into the next drain
  assign capture = !start && vec_valid &&
                   (state == IDLE || (fire && last_beat && !last_pix));
  assign wr_valid = state == DRAIN;
  assign busy = state == DRAIN;
  assign done = state == DONE;
  assign wr_addr = wr_valid ? ADDR_W'(pixel) * ADDR_W'(CH_TOTAL / LANES) +
                              ADDR_W'(CH_OFFSET / LANES) + ADDR_W'(beat) : '0;
  assign wr_data = wr_valid ? shadow[int'(beat)*LANES*WIDTH +: LANES*WIDTH] : '0;
  always_ff @(posedge clk)
    if (capture) shadow <= flat_in;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pixel <= '0;
      beat <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      state <= IDLE;
      pixel <= '0;
      beat <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (vec_valid) begin
          beat <= '0;
          state <= DRAIN;
        end
        DRAIN: begin
          if (fire && last_beat) begin
            beat <= '0;
            pixel <= pixel + 1'b1;
            state <= last_pix ? DONE : vec_valid ? DRAIN : IDLE;
          end else if (fire) beat <= beat + 1'b1;
          if (vec_valid && !(fire && last_beat)) overflow <= 1'b1;
        end
        default: state <= DONE;
      endcase
    end
endmodule

// File: tb/tb_fire7_ex_1_ofm_writer.sv
// tb_fire7_ex_1_ofm_writer: directed checks of drain order, addressing, backpressure, overflow and done
module tb_fire7_ex_1_ofm_writer;
  logic clk = 0, rst = 0, start = 0, vec_valid = 0, wr_ready = 0;
  logic [15:0] vec_in [192];
  logic wr_valid, busy, overflow, done;
  logic [14:0] wr_addr;
  logic [63:0] wr_data;
  logic wr_valid3, busy3, overflow3, done3;
  logic [14:0] wr_addr3;
  logic [63:0] wr_data3;
  int asserts = 0, fails = 0;

  always #5 clk = ~clk;

  fire7_ex_1_ofm_writer dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_in(vec_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .overflow(overflow), .done(done)
  );

  fire7_ex_1_ofm_writer #(.CH_OFFSET(192)) dut_ex3 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_in(vec_in),
    .wr_valid(wr_valid3), .wr_ready(wr_ready), .wr_addr(wr_addr3), .wr_data(wr_data3),
    .busy(busy3), .overflow(overflow3), .done(done3)
  );

  task automatic load(input int base);
    for (int i = 0; i < 192; i++) vec_in[i] = 16'(base + i);
  endtask

  task automatic pulse(input int base);
    load(base);
    vec_valid = 1;
    @(posedge clk); #1;
    vec_valid = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // checks one full unstalled drain; optionally injects a dropped or chained vector
  task automatic drain(input int pix, input int base, input int drop_at, input int b2b_base, input string nm);
    logic [63:0] exp;
    wr_ready = 1;
    for (int b = 0; b < 48; b++) begin
      if (b == drop_at) begin load(base + 1000); vec_valid = 1; end
      if (b == 47 && b2b_base >= 0) begin load(b2b_base); vec_valid = 1; end
      @(negedge clk);
      for (int k = 0; k < 4; k++) exp[k*16 +: 16] = 16'(base + b*4 + k);
      asserts++;
      if (wr_valid !== 1'b1 || wr_addr !== 15'(pix*96 + b)) begin
        fails++;
        $display("FAIL %s addr beat %0d: valid=%0b addr=%0d, expected valid=1 addr=%0d", nm, b, wr_valid, wr_addr, pix*96 + b);
      end
      asserts++;
      if (wr_data !== exp) begin
        fails++;
        $display("FAIL %s data beat %0d: got %h expected %h", nm, b, wr_data, exp);
      end
      asserts++;
      if (wr_addr3 !== 15'(pix*96 + 48 + b)) begin
        fails++;
        $display("FAIL %s ex3 addr beat %0d: got %0d expected %0d", nm, b, wr_addr3, pix*96 + 48 + b);
      end
      @(posedge clk); #1;
      vec_valid = 0;
    end
    if (b2b_base < 0) begin
      @(negedge clk);
      asserts++;
      if (busy !== 1'b0 || wr_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s end: busy=%0b valid=%0b expected 0 0", nm, busy, wr_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    load(0);
    #3;
    asserts++;
    if ({wr_valid, busy, overflow, done} !== 4'b0 || wr_addr !== 15'd0 || wr_data !== 64'd0) begin
      fails++;
      $display("FAIL reset: valid=%0b busy=%0b ovf=%0b done=%0b addr=%0d data=%h expected all 0",
               wr_valid, busy, overflow, done, wr_addr, wr_data);
    end
    #19 rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_start();
    pulse(0);
    drain(0, 0, -1, -1, "single");
  endtask

  task automatic test_second_pixel();
    pulse('h100);
    drain(1, 'h100, -1, -1, "second");
  endtask

  task automatic test_backpressure();
    int nb = 0;
    logic [63:0] exp;
    pulse('h200);
    for (int c = 0; c < 300 && nb < 48; c++) begin
      wr_ready = (c % 3 == 0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) exp[k*16 +: 16] = 16'('h200 + nb*4 + k);
      asserts++;
      if (wr_valid !== 1'b1 || wr_addr !== 15'(192 + nb) || wr_data !== exp) begin
        fails++;
        $display("FAIL bp cycle %0d: valid=%0b addr=%0d data=%h, expected 1 %0d %h", c, wr_valid, wr_addr, wr_data, 192 + nb, exp);
      end
      if (wr_valid && wr_ready) nb++;
      @(posedge clk); #1;
    end
    wr_ready = 1;
    @(negedge clk);
    asserts++;
    if (nb !== 48 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp end: beats=%0d busy=%0b expected 48 0", nb, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    pulse('h300);
    drain(3, 'h300, -1, 'h400, "b2b_first");
    drain(4, 'h400, -1, -1, "b2b_second");
    asserts++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b overflow: got %0b expected 0", overflow);
    end
  endtask

  task automatic test_drop();
    pulse('h500);
    drain(5, 'h500, 10, -1, "drop");
    asserts++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL drop overflow: got %0b expected 1", overflow);
    end
  endtask

  task automatic test_full_layer();
    int acc = 0;
    int last_addr = -1;
    do_start();
    asserts++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL start clears overflow: got %0b expected 0", overflow);
    end
    wr_ready = 1;
    for (int p = 0; p < 256; p++) begin
      pulse(p);
      repeat (64) begin
        @(negedge clk);
        if (wr_valid && wr_ready) begin acc++; last_addr = int'(wr_addr); end
        @(posedge clk); #1;
      end
      if (p == 254) begin
        asserts++;
        if (done !== 1'b0) begin
          fails++;
          $display("FAIL early done: got %0b expected 0", done);
        end
      end
    end
    @(negedge clk);
    asserts++;
    if (done !== 1'b1 || acc != 12288 || last_addr != 24527) begin
      fails++;
      $display("FAIL layer: done=%0b beats=%0d last_addr=%0d expected 1 12288 24527", done, acc, last_addr);
    end
    @(posedge clk); #1;
    pulse(7);
    @(negedge clk);
    asserts++;
    if (wr_valid !== 1'b0 || done !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL done ignore: valid=%0b done=%0b ovf=%0b expected 0 1 0", wr_valid, done, overflow);
    end
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL start clears done: got %0b expected 0", done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_drain();
    pulse('h600);
    repeat (20) begin @(posedge clk); #1; end
    rst = 0;
    #1;
    asserts++;
    if (wr_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== 15'd0) begin
      fails++;
      $display("FAIL mid reset: valid=%0b busy=%0b addr=%0d expected 0 0 0", wr_valid, busy, wr_addr);
    end
    #2 rst = 1;
    @(posedge clk); #1;
    pulse('h700);
    drain(0, 'h700, -1, -1, "post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_second_pixel();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_full_layer();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/fire7_ex_1_ofm_writer.md
Name: fire7_ex_1_ofm_writer

Overview:
- Downstream consumer of the fire7 expand-1x1 stage: captures each DSP_NO-wide output vector (one per pixel, strobed every CHIN+1 cycles).
- Serializes the vector into LANES-wide words with a valid/ready handshake.
- Writes the words into the fire7 concatenated feature-map buffer (expand-1x1 channels at CH_OFFSET, expand-3x3 channels elsewhere).
- Raises done after the last pixel of the layer is written.

Parameters:
- DSP_NO, 192, channels per captured vector (expand-1x1 CHOUT)
- WIDTH, 16, bits per channel value
- LANES, 4, channel values per write word
- NPIX, 256, pixels per layer (16*16)
- CH_TOTAL, 384, channels per pixel in the concatenated buffer
- CH_OFFSET, 0, first channel slot of this branch in the concat buffer
- BEATS, DSP_NO/LANES (48), write beats per vector (derived)
- ADDR_W, $clog2(NPIX*CH_TOTAL/LANES) (15), word address width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  synchronous pulse; clears counters, done and overflow
- vec_valid  in  1  one-cycle strobe; vec_in holds a new pixel vector
- vec_in  in  [WIDTH-1:0] x DSP_NO  unpacked array; channel i at index i
- wr_valid  out  1  write word valid
- wr_ready  in  1  buffer accepts the word this cycle
- wr_addr  out  ADDR_W  word address
- wr_data  out  LANES*WIDTH  lane k = channel beat*LANES+k, in bits [k*WIDTH +: WIDTH]
- busy  out  1  vector held, not fully written
- overflow  out  1  sticky; a vector was dropped
- done  out  1  sticky; all NPIX vectors written

Behaviour:
- Reset (asynchronous, rst low): state=IDLE; pixel=0; beat=0; all outputs 0; shadow register contents don't care.
- States:
  - IDLE: wr_valid=0, busy=0.
  - DRAIN: wr_valid=1, busy=1.
  - DONE: done=1, wr_valid=0.
- IDLE, vec_valid=1: latch vec_in into the shadow register; beat<=0; go to DRAIN.
- DRAIN outputs:
  - wr_data = shadow[beat*LANES .. beat*LANES+LANES-1].
  - wr_addr = pixel*(CH_TOTAL/LANES) + CH_OFFSET/LANES + beat.
- DRAIN beat advance: a beat completes on a cycle with wr_valid&&wr_ready. On completion: if beat<BEATS-1, beat++.
- DRAIN final beat completion: beat=0 and pixel++.
  - If pixel was NPIX-1: go to DONE.
  - Else if vec_valid in the same cycle: capture and stay in DRAIN. No bubble, no overflow.
  - Else: go to IDLE.
- Stall: while wr_ready=0, wr_data and wr_addr hold stable; wr_valid stays high and is never withdrawn.
- vec_valid in DRAIN other than on the final completing cycle:
  - overflow<=1; the vector is dropped.
  - The in-progress drain and the pixel count are unaffected.
- DONE: vec_valid is ignored; overflow is not set. State exits only via start or rst.
- start:
  - Any state goes to IDLE; pixel=0; done=0; overflow=0; wr_valid drops the next cycle.
  - start and vec_valid in the same cycle: start wins; the vector is not captured.
- Latency and throughput:
  - vec_valid at cycle t: first beat presented at t+1.
  - With wr_ready held high, the last beat is accepted at t+BEATS (t+48).
  - BEATS ≤ CHIN+1 (65), so an unstalled writer never overflows.
- Address arithmetic: unsigned, ADDR_W bits, no wrap within legal params.
- Elaboration errors:
  - DSP_NO, CH_TOTAL or CH_OFFSET not a multiple of LANES.
  - CH_OFFSET+DSP_NO > CH_TOTAL.
- Data is passed through untouched; ReLU and bias are applied upstream.

Decomposition:
- Shared package fire7_pkg holds:
  - state enum (IDLE, DRAIN, DONE);
  - constants FIRE7_NPIX=256, FIRE7_CH_TOTAL=384, FIRE7_EX1_OFFSET=0, FIRE7_EX3_OFFSET=192.
- Single module, no sub-module. The shadow register and lane mux are inline; the mux is an indexed part-select on the flattened shadow.

Test Plan:
- Single vector: vec_in[i]=i, wr_ready=1.
  - Exactly 48 beats at addr 0..47.
  - Beat 0 data 0x0003_0002_0001_0000; beat 47 lanes {191,190,189,188}.
  - busy falls the cycle after beat 47.
- Second pixel: default params give addr 96..143. With CH_OFFSET=192, pixel 0 gives addr 48..95.
- Backpressure: wr_ready pattern 1,0,0,1,...
  - wr_addr and wr_data stable across stalls.
  - 48 accepted beats, no duplicate or skipped address.
- Drop vs. back-to-back:
  - vec_valid during beat 10: overflow=1; original data still written in full.
  - vec_valid on the final accepted beat: overflow stays 0; the next pixel's beat 0 follows with no gap.
- Full layer: 256 vectors spaced 65 cycles, wr_ready=1.
  - done=1 after pixel 255 beat 47; last addr 24527.
  - Later vec_valid ignored; start clears done.
- Reset mid-drain (rst low at beat 20): wr_valid, busy and wr_addr go to 0 immediately. After release, the next vector writes from pixel 0.
